alu_mc_core: RTL
================

Name: alu_mc_core

Overview:
Parametrised, multi-cycle successor to the 16-bit ALU top. Uses the same 4-bit function encoding, but adds several things the existing block lacks:
- a valid/ready handshake on both input and output;
- an iterative shift-add multiplier and a restoring divider;
- remainder output and divide-by-zero detection.
It sits between the operand-issue logic and the result write-back stage. One operation is in flight at a time.

Parameters:
OPERAND_W, 16, operand width in bits (>=4).
OUT_W, 2*OPERAND_W, result width. Must equal 2*OPERAND_W.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
IN_VALID  input  1  operands/function valid.
IN_READY  output  1  block can accept an operation this cycle.
A  input  OPERAND_W  operand A, unsigned.
B  input  OPERAND_W  operand B, unsigned.
ALU_FUN  input  4  function code.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  consumer takes the result.
ALU_OUT  output  OUT_W  result.
CARRY_OUT  output  1  add carry / sub borrow.
ZERO_FLAG  output  1  ALU_OUT == 0.
DIV_BY_ZERO  output  1  divide issued with B == 0.
CLASS_FLAG  output  4  one-hot class: [0] arith, [1] logic, [2] cmp, [3] shift.
BUSY  output  1  MUL or DIV iteration in progress.

Behaviour:
Clock, reset and handshake
- One clock (CLK). Reset (RST) is asynchronous, active-high.
- While RST is high: state=IDLE; OUT_VALID, ALU_OUT, CARRY_OUT, ZERO_FLAG, DIV_BY_ZERO, CLASS_FLAG, BUSY all 0; iteration counter 0.
- Reset during MUL/DIV abandons the operation. No result is ever emitted for it.
- Accept = IN_VALID & IN_READY at a rising edge. A, B and ALU_FUN are registered on accept.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY), combinational.
- Back-to-back accept in DONE is allowed: the old result retires and the new operation starts on the same edge.

State machine
- IDLE -> DONE: accepted single-cycle op, or DIV with B==0.
- IDLE -> MUL: accepted op 0010.
- IDLE -> DIV: accepted op 0011 with B!=0.
- MUL / DIV: run exactly OPERAND_W iterations, counter OPERAND_W-1 down to 0; at count 0 go to DONE.
- DONE: OUT_VALID=1, all outputs held stable. Leave on OUT_READY: go to IDLE, or to the next state if a new op is accepted on the same edge.

Latency (accept edge k)
- Single-cycle ops: OUT_VALID high after edge k+1.
- MUL/DIV: OUT_VALID high after edge k+OPERAND_W+1.
- BUSY = state in {MUL, DIV}.

Functions (operands zero-extended to OUT_W)
- 0000 add: A+B; CARRY_OUT = sum[OPERAND_W].
- 0001 sub: A-B mod 2^OUT_W; CARRY_OUT = (A<B).
- 0010 mul: full A*B.
- 0011 div: ALU_OUT[OPERAND_W-1:0] = A/B, ALU_OUT[OUT_W-1:OPERAND_W] = A%B.
- Divide by zero: ALU_OUT all ones, DIV_BY_ZERO=1, latency 1.
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR: computed at OUT_W width, so NAND/NOR set the upper bits.
- 1000 NOP: ALU_OUT=0, CLASS_FLAG=0.
- 1001 / 1010 / 1011: ALU_OUT = 1 / 2 / 3 if A==B / A>B / A<B is true, else 0.
- 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1: logical shifts. The left-shift MSB is kept in OUT_W.

Flags
- CARRY_OUT = 0 for every op other than add/sub.
- DIV_BY_ZERO = 0 for every result other than divide-by-zero.
- ZERO_FLAG is computed on the final ALU_OUT.
- CLASS_FLAG is set with the result and held until the result retires.

Test Plan (OPERAND_W=16, A=128, B=8 unless stated):
1. Add, OUT_READY=1 -> ALU_OUT=136, CARRY_OUT=0, CLASS_FLAG=0001, OUT_VALID one cycle after accept. Repeat with NOR -> 0xFFFFFF77, CLASS_FLAG=0010.
2. Mul -> BUSY=1 and IN_READY=0 for 16 cycles; OUT_VALID 17 cycles after accept; ALU_OUT=1024.
3. Div 128/8 -> ALU_OUT=0x00000010. Div A=131, B=8 -> ALU_OUT=0x00030010. B=0 -> ALU_OUT=0xFFFFFFFF, DIV_BY_ZERO=1 after 1 cycle.
4. Sub A=8, B=128 -> ALU_OUT=0xFFFFFF88, CARRY_OUT=1. Compare 1010 -> ALU_OUT=2. Compare 1001 -> ALU_OUT=0, ZERO_FLAG=1.
5. Shift 1101 with OUT_READY=0 for 5 cycles -> ALU_OUT=256 stable, OUT_VALID stays 1, IN_READY=0. Then assert OUT_READY together with IN_VALID (op 1110) -> second result 4 follows on the next cycle with no idle gap.
6. Assert RST for 2 cycles mid-MUL (iteration 7) -> all outputs 0 asynchronously, IN_READY=1 after release, no stale result. A following add produces 136.

Source files
------------

// File: rtl/alu_mc_core.sv
// alu_mc_core: multi-cycle ALU with valid/ready handshakes, shift-add
// multiplier, restoring divider and divide-by-zero detection.
module alu_mc_core #(
    parameter int OPERAND_W = 16,
    parameter int OUT_W     = 2 * OPERAND_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    input  logic [3:0]           ALU_FUN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OUT_W-1:0]     ALU_OUT,
    output logic                 CARRY_OUT,
    output logic                 ZERO_FLAG,
    output logic                 DIV_BY_ZERO,
    output logic [3:0]           CLASS_FLAG,
    output logic                 BUSY
);

    localparam int W  = OPERAND_W;
    localparam int CW = $clog2(OPERAND_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   work_q, work_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic [3:0]       cls_q, cls_d;

    logic             accept;
    logic [W:0]       sum;
    logic [OUT_W-1:0] ax, bx;
    logic [OUT_W-1:0] sc_res;
    logic             sc_carry;
    logic [3:0]       sc_cls;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_nxt;
    logic [W:0]       div_sh;
    logic [W:0]       div_diff;
    logic [2*W-1:0]   div_nxt;

    assign IN_READY    = (state_q == S_IDLE) ||
                         ((state_q == S_DONE) && OUT_READY);
    assign accept      = IN_VALID && IN_READY;
    assign OUT_VALID   = (state_q == S_DONE);
    assign BUSY        = (state_q == S_MUL) || (state_q == S_DIV);
    assign ALU_OUT     = res_q;
    assign CARRY_OUT   = carry_q;
    assign ZERO_FLAG   = zero_q;
    assign DIV_BY_ZERO = dbz_q;
    assign CLASS_FLAG  = cls_q;

    // Single-cycle datapath, evaluated straight from the input operands.
    always_comb begin
        ax       = OUT_W'(A);
        bx       = OUT_W'(B);
        sum      = {1'b0, A} + {1'b0, B};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_cls   = 4'b0000;
        case (ALU_FUN)
            4'b0000: begin
                sc_res   = ax + bx;
                sc_carry = sum[W];
                sc_cls   = 4'b0001;
            end
            4'b0001: begin
                sc_res   = ax - bx;
                sc_carry = (A < B);
                sc_cls   = 4'b0001;
            end
            4'b0011: begin
                sc_res = '1;
                sc_cls = 4'b0001;
            end
            4'b0100: begin
                sc_res = ax & bx;
                sc_cls = 4'b0010;
            end
            4'b0101: begin
                sc_res = ax | bx;
                sc_cls = 4'b0010;
            end
            4'b0110: begin
                sc_res = ~(ax & bx);
                sc_cls = 4'b0010;
            end
            4'b0111: begin
                sc_res = ~(ax | bx);
                sc_cls = 4'b0010;
            end
            4'b1001: begin
                sc_res = (A == B) ? OUT_W'(1) : '0;
                sc_cls = 4'b0100;
            end
            4'b1010: begin
                sc_res = (A > B) ? OUT_W'(2) : '0;
                sc_cls = 4'b0100;
            end
            4'b1011: begin
                sc_res = (A < B) ? OUT_W'(3) : '0;
                sc_cls = 4'b0100;
            end
            4'b1100: begin
                sc_res = ax >> 1;
                sc_cls = 4'b1000;
            end
            4'b1101: begin
                sc_res = ax << 1;
                sc_cls = 4'b1000;
            end
            4'b1110: begin
                sc_res = bx >> 1;
                sc_cls = 4'b1000;
            end
            4'b1111: begin
                sc_res = bx << 1;
                sc_cls = 4'b1000;
            end
            default: begin
                sc_res   = '0;
                sc_carry = 1'b0;
                sc_cls   = 4'b0000;
            end
        endcase
    end

    // work_q = {hi, lo}: product accumulator / {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*W-1:W]} +
                   {1'b0, (work_q[0] ? a_q : {W{1'b0}})};
        mul_nxt  = {mul_sum, work_q[W-1:1]};
        div_sh   = {work_q[2*W-1:W], work_q[W-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_nxt  = div_diff[W] ?
                   {div_sh[W-1:0], work_q[W-2:0], 1'b0} :
                   {div_diff[W-1:0], work_q[W-2:0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        cls_d   = cls_q;
        case (state_q)
            S_MUL, S_DIV: begin
                work_d = (state_q == S_MUL) ? mul_nxt : div_nxt;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = OUT_W'(work_d);
                    carry_d = 1'b0;
                    zero_d  = (work_d == '0);
                    dbz_d   = 1'b0;
                    cls_d   = 4'b0001;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (OUT_READY) state_d = S_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (accept) begin
            a_d   = A;
            b_d   = B;
            cnt_d = CW'(W - 1);
            if (ALU_FUN == 4'b0010) begin
                state_d = S_MUL;
                work_d  = {{W{1'b0}}, B};
            end else if ((ALU_FUN == 4'b0011) && (B != '0)) begin
                state_d = S_DIV;
                work_d  = {{W{1'b0}}, A};
            end else begin
                state_d = S_DONE;
                res_d   = sc_res;
                carry_d = sc_carry;
                zero_d  = (sc_res == '0);
                dbz_d   = (ALU_FUN == 4'b0011);
                cls_d   = sc_cls;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            cls_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            cls_q   <= cls_d;
        end
    end

endmodule
